half_adder: RTL and testbench

- Registered, WIDTH-lane bitwise half adder with valid/ready handshake on input and output.
- Per lane: sum = a XOR b, carry = a AND b.
- Also reports how many lanes produced a carry.
- Used as a leaf arithmetic stage in datapaths that need per-bit generate/propagate terms with flow control.

---
 rtl/half_adder_pkg.sv | 30 +++
 rtl/half_adder_lane.sv | 12 +
 rtl/half_adder.sv | 104 ++++++++++
 tb/tb_half_adder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and helpers for the half_adder block: count-width sizing and
// the carry population count.
package half_adder_pkg;

   localparam int MAX_WIDTH = 32'sd64;
   localparam int CNT_MAX_W = 32'sd7;

   typedef logic [MAX_WIDTH-1:0] lane_vec_t;

   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width + 32'sd1);
      if (w < 32'sd1) begin
         return 32'sd1;
      end else begin
         return w;
      end
   endfunction

   // Lanes above the instance WIDTH are expected to be zero-filled by the caller.
   function automatic logic [CNT_MAX_W-1:0] popcount(input lane_vec_t v);
      logic [CNT_MAX_W-1:0] n;
      n = {CNT_MAX_W{1'b0}};
      for (int i = 32'sd0; i < MAX_WIDTH; i++) begin
         n = n + {{(CNT_MAX_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/half_adder_lane.sv
// One combinational half-adder lane: sum = a ^ b, carry = a & b.
module half_adder_lane (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder with valid/ready flow control and carry count.
// Optional macro HALF_ADDER_BYPASS_EN adds combinational sum_comb/carry_comb ports.
module half_adder
   import half_adder_pkg::*;
#(
   parameter  int WIDTH = 32'sd1,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
`ifdef HALF_ADDER_BYPASS_EN
   output logic [WIDTH-1:0] sum_comb,
   output logic [WIDTH-1:0] carry_comb,
`endif
   output logic [CNT_W-1:0] carry_cnt
);

   typedef logic [WIDTH-1:0] lane_t;

   typedef struct packed {
      lane_t sum;
      lane_t carry;
   } ha_result_t;

   lane_t      sum_s;
   lane_t      carry_s;
   lane_vec_t  carry_vec_s;
   logic       accept_s;

   logic       out_valid_q;
   logic       out_valid_d;
   ha_result_t res_q;
   ha_result_t res_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_lane u_lane (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (sum_s[i]),
         .carry (carry_s[i])
      );
   end

   // The output register frees up whenever it is empty or being drained.
   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready;

   // Zero-extend the live lanes so the package popcount sees a full vector.
   always_comb begin
      carry_vec_s = {MAX_WIDTH{1'b0}};
      carry_vec_s[WIDTH-1:0] = carry_s;
   end

   // Next-state for the valid flag and the result registers.
   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         res_d.sum   = sum_s;
         res_d.carry = carry_s;
         cnt_d       = CNT_W'(popcount(carry_vec_s));
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Result and valid registers; asynchronous reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= {(2*WIDTH){1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = res_q.sum;
   assign carry     = res_q.carry;
   assign carry_cnt = cnt_q;

`ifdef HALF_ADDER_BYPASS_EN
   assign sum_comb   = sum_s;
   assign carry_comb = carry_s;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: directed cases on WIDTH=1 and WIDTH=4
// instances plus randomized traffic against a queue-based reference model.
module tb_half_adder;

   logic       clk;
   logic       rst_n;

   logic       in_valid1, in_ready1, out_valid1, out_ready1;
   logic [0:0] a1, b1, sum1, carry1, cnt1;

   logic       in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0] a4, b4, sum4, carry4;
   logic [2:0] cnt4;

`ifdef HALF_ADDER_BYPASS_EN
   logic [0:0] sum_comb1, carry_comb1;
   logic [3:0] sum_comb4, carry_comb4;
`endif

   int n_checks;
   int n_errors;

   typedef struct {
      logic [3:0] s;
      logic [3:0] c;
      int         n;
   } exp_t;

   exp_t exp_q[$];

   half_adder #(.WIDTH(1)) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid1),
      .in_ready   (in_ready1),
      .a          (a1),
      .b          (b1),
      .out_valid  (out_valid1),
      .out_ready  (out_ready1),
      .sum        (sum1),
      .carry      (carry1),
`ifdef HALF_ADDER_BYPASS_EN
      .sum_comb   (sum_comb1),
      .carry_comb (carry_comb1),
`endif
      .carry_cnt  (cnt1)
   );

   half_adder #(.WIDTH(4)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .a          (a4),
      .b          (b4),
      .out_valid  (out_valid4),
      .out_ready  (out_ready4),
      .sum        (sum4),
      .carry      (carry4),
`ifdef HALF_ADDER_BYPASS_EN
      .sum_comb   (sum_comb4),
      .carry_comb (carry_comb4),
`endif
      .carry_cnt  (cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: each lane adds two one-bit numbers; the two-bit total splits
   // into a sum digit and a carry digit.
   function automatic exp_t model_ha(input logic [3:0] a, input logic [3:0] b);
      exp_t r;
      int   t;
      r.s = 4'd0;
      r.c = 4'd0;
      r.n = 0;
      for (int i = 0; i < 4; i++) begin
         t = int'(a[i]) + int'(b[i]);
         r.s[i] = (t % 2) == 1;
         r.c[i] = (t / 2) == 1;
         r.n    = r.n + t / 2;
      end
      return r;
   endfunction

   logic [1:0] pat;
   logic [3:0] b2b_a[8];
   logic [3:0] b2b_b[8];
   exp_t       e;
   logic       exp_valid;

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      in_valid1  = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      in_valid4  = 1'b0; out_ready4 = 1'b0; a4 = 4'd0; b4 = 4'd0;

`ifdef HALF_ADDER_BYPASS_EN
      a1 = 1'b1; b1 = 1'b0;
      #2;
      check_eq("bypass_sum_in_reset", 32'(sum_comb1), 32'd1);
      check_eq("bypass_carry_in_reset", 32'(carry_comb1), 32'd0);
      a1 = 1'b0;
`endif

      #10;
      check_eq("rst_valid1", 32'(out_valid1), 32'd0);
      check_eq("rst_sum1", 32'(sum1), 32'd0);
      check_eq("rst_carry1", 32'(carry1), 32'd0);
      check_eq("rst_cnt1", 32'(cnt1), 32'd0);
      check_eq("rst_valid4", 32'(out_valid4), 32'd0);
      check_eq("rst_sum4", 32'(sum4), 32'd0);
      check_eq("rst_carry4", 32'(carry4), 32'd0);
      check_eq("rst_cnt4", 32'(cnt4), 32'd0);
      check_eq("rst_in_ready4", 32'(in_ready4), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // WIDTH=1 truth table, back-to-back with out_ready held high.
      for (int k = 0; k < 4; k++) begin
         pat        = 2'(k);
         a1         = pat[1];
         b1         = pat[0];
         in_valid1  = 1'b1;
         out_ready1 = 1'b1;
         @(posedge clk);
         #1;
         e = model_ha({3'd0, pat[1]}, {3'd0, pat[0]});
         check_eq("w1_valid", 32'(out_valid1), 32'd1);
         check_eq("w1_sum", 32'(sum1), 32'(e.s[0]));
         check_eq("w1_carry", 32'(carry1), 32'(e.c[0]));
         check_eq("w1_cnt", 32'(cnt1), 32'(e.n));
      end
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;

      // WIDTH=4 single accept.
      a4 = 4'b1100; b4 = 4'b1010; in_valid4 = 1'b1; out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      check_eq("w4_sum", 32'(sum4), 32'h6);
      check_eq("w4_carry", 32'(carry4), 32'h8);
      check_eq("w4_cnt", 32'(cnt4), 32'd1);
      check_eq("w4_valid", 32'(out_valid4), 32'd1);

      // All-ones result then 3 cycles of backpressure with conflicting input.
      a4 = 4'hF; b4 = 4'hF;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      a4 = 4'h0; b4 = 4'h5; in_valid4 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("hold_in_ready", 32'(in_ready4), 32'd0);
         @(posedge clk);
         #1;
         check_eq("hold_valid", 32'(out_valid4), 32'd1);
         check_eq("hold_sum", 32'(sum4), 32'h0);
         check_eq("hold_carry", 32'(carry4), 32'hF);
         check_eq("hold_cnt", 32'(cnt4), 32'd4);
      end
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;
      #1;
      check_eq("drain_in_ready", 32'(in_ready4), 32'd1);
      @(posedge clk);
      #1;
      check_eq("drain_valid", 32'(out_valid4), 32'd0);
      check_eq("drain_carry_kept", 32'(carry4), 32'hF);

      // 8 back-to-back results, one per cycle, in order.
      for (int k = 0; k < 8; k++) begin
         b2b_a[k] = 4'($urandom_range(0, 15));
         b2b_b[k] = 4'($urandom_range(0, 15));
      end
      for (int k = 0; k < 8; k++) begin
         a4 = b2b_a[k]; b4 = b2b_b[k]; in_valid4 = 1'b1; out_ready4 = 1'b1;
         @(posedge clk);
         #1;
         e = model_ha(b2b_a[k], b2b_b[k]);
         check_eq("b2b_valid", 32'(out_valid4), 32'd1);
         check_eq("b2b_sum", 32'(sum4), 32'(e.s));
         check_eq("b2b_carry", 32'(carry4), 32'(e.c));
         check_eq("b2b_cnt", 32'(cnt4), 32'(e.n));
      end

      // Asynchronous reset mid-cycle while both instances hold a result.
      a4 = 4'hF; b4 = 4'hE; in_valid4 = 1'b1; out_ready4 = 1'b0;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      check_eq("pre_rst_valid4", 32'(out_valid4), 32'd1);
      check_eq("pre_rst_valid1", 32'(out_valid1), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid4", 32'(out_valid4), 32'd0);
      check_eq("arst_sum4", 32'(sum4), 32'd0);
      check_eq("arst_carry4", 32'(carry4), 32'd0);
      check_eq("arst_cnt4", 32'(cnt4), 32'd0);
      check_eq("arst_valid1", 32'(out_valid1), 32'd0);
      check_eq("arst_cnt1", 32'(cnt1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with random backpressure against the queue model.
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         in_valid4  = 1'($urandom_range(0, 1));
         out_ready4 = ($urandom_range(0, 3) != 0);
         a4         = 4'($urandom_range(0, 15));
         b4         = 4'($urandom_range(0, 15));
         @(negedge clk);
         exp_valid = (exp_q.size() != 0);
         check_eq("rnd_valid", 32'(out_valid4), 32'(exp_valid));
         check_eq("rnd_in_ready", 32'(in_ready4), 32'(!exp_valid || out_ready4));
         check_eq("rnd_exclusive", 32'(sum4 & carry4), 32'd0);
         if (exp_valid) begin
            check_eq("rnd_sum", 32'(sum4), 32'(exp_q[0].s));
            check_eq("rnd_carry", 32'(carry4), 32'(exp_q[0].c));
            check_eq("rnd_cnt", 32'(cnt4), 32'(exp_q[0].n));
            if (out_ready4) begin
               void'(exp_q.pop_front());
            end
         end
         if (in_valid4 && (!exp_valid || out_ready4)) begin
            exp_q.push_back(model_ha(a4, b4));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
